// File: rtl/fifo_pkg.sv
// ============================================================================
// fifo_pkg
// ----------------------------------------------------------------------------
// Purpose
//    Shared types and constants for the FIFO read-side stream adapter
//    (fifo_stream_reader) and its small skid/circular buffer (stream_buf).
//
// Contents
//    STREAM_BUF_DEPTH  number of words the stream buffer can hold
//    buf_ptr_t         read/write pointer into the stream buffer
//    buf_cnt_t         occupancy count of the stream buffer (0..3)
//    nextPtr()         pointer increment with wrap at the buffer depth
// ============================================================================

package fifo_pkg;

   // Three entries are exactly enough to cover the two-cycle round trip of a
   // standard-mode FIFO read (request, then data) plus one word sitting on the
   // output, so the reader can keep streaming at one word per cycle and still
   // never over-issue when the downstream stalls.
   localparam int STREAM_BUF_DEPTH = 3;

   typedef logic [1:0] buf_ptr_t;
   typedef logic [1:0] buf_cnt_t;

   // Pointers run 0,1,2,0,... rather than using the natural 2-bit wrap,
   // because the buffer depth is not a power of two.
   function automatic buf_ptr_t nextPtr(input buf_ptr_t ptr);
      buf_ptr_t result;
      if (ptr == buf_ptr_t'(STREAM_BUF_DEPTH - 1)) begin
         result = '0;
      end else begin
         result = ptr + buf_ptr_t'(1);
      end
      return result;
   endfunction

endpackage

// File: rtl/fifo_stream_reader_stream_buf.sv
// ============================================================================
// stream_buf
// ----------------------------------------------------------------------------
// Purpose
//    Three-entry circular buffer that holds words returned by the FIFO until
//    the downstream consumer takes them. Handles pointer wrap and the
//    simultaneous push/pop case internally so the parent only has to say
//    "a word arrived" and "a word left".
//
// Ports
//    CLK      in   clock
//    RST      in   synchronous active-high reset, clears pointers and count
//    push_i   in   write data_i into the next free slot this cycle
//    pop_i    in   release the oldest word this cycle
//    data_i   in   word to store on push
//    data_o   out  oldest stored word (head of the buffer)
//    cnt_o    out  number of words currently stored, 0..3
// ============================================================================

module stream_buf
   import fifo_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o,
   output buf_cnt_t         cnt_o
);

   logic [WIDTH-1:0] mem_q [STREAM_BUF_DEPTH];

   buf_ptr_t wrPtr_q;
   buf_ptr_t wrPtr_d;
   buf_ptr_t rdPtr_q;
   buf_ptr_t rdPtr_d;
   buf_cnt_t cnt_q;
   buf_cnt_t cnt_d;

   logic doPush;
   logic doPop;

   // Qualify the raw requests against the occupancy. A pop of an empty
   // buffer is ignored, and a push into a full buffer is only taken when a
   // pop frees a slot in the same cycle. The parent never asks for either
   // illegal case, but guarding here keeps the pointers and count coherent
   // even if it ever did.
   always_comb begin
      doPop  = pop_i & (cnt_q != buf_cnt_t'(0));
      doPush = push_i & ((cnt_q != buf_cnt_t'(STREAM_BUF_DEPTH)) | doPop);
   end

   // Next-state for pointers and occupancy. Push and pop together leave the
   // count untouched, whatever its current value; each pointer still moves.
   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      cnt_d   = cnt_q;
      if (doPush) begin
         wrPtr_d = nextPtr(wrPtr_q);
      end
      if (doPop) begin
         rdPtr_d = nextPtr(rdPtr_q);
      end
      unique case ({doPush, doPop})
         2'b10:   cnt_d = cnt_q + buf_cnt_t'(1);
         2'b01:   cnt_d = cnt_q - buf_cnt_t'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // Control state register. Reset empties the buffer; the stored words are
   // simply abandoned because the count says none are valid.
   always_ff @(posedge CLK) begin
      if (RST) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         cnt_q   <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         cnt_q   <= cnt_d;
      end
   end

   // Storage array. It has no reset: the data is meaningless until the count
   // marks a slot as occupied, so clearing it would buy nothing.
   always_ff @(posedge CLK) begin
      if (doPush) begin
         mem_q[wrPtr_q] <= data_i;
      end
   end

   // The head word is read straight out of the array, so it stays put for as
   // long as the read pointer does, which is what keeps the output stable
   // under backpressure.
   always_comb begin
      data_o = mem_q[rdPtr_q];
      cnt_o  = cnt_q;
   end

endmodule

// File: rtl/fifo_stream_reader.sv
// ============================================================================
// fifo_stream_reader
// ----------------------------------------------------------------------------
// Purpose
//    Read-side consumer for a standard-mode (non first-word-fall-through)
//    sync FIFO, where read data appears with VALID one cycle after RD_EN.
//    Issues reads, catches the returned words in a 3-entry buffer and
//    presents them as a valid/ready stream that sustains one word per cycle
//    under arbitrary backpressure.
//
// Parameters
//    WIDTH    data word width, must match the FIFO
//    PKT_LEN  beats per packet for M_TLAST (only used with TLAST enabled)
//
// Ports
//    CLK             in   clock
//    RST             in   synchronous active-high reset (reset the FIFO too)
//    FIFO_RD_EN      out  read request to the FIFO
//    FIFO_VALID      in   FIFO read data present this cycle
//    FIFO_RD_DATA    in   FIFO read data
//    FIFO_EMPTY      in   FIFO empty flag
//    FIFO_UNDERFLOW  in   FIFO underflow flag
//    M_TVALID        out  output word valid
//    M_TDATA         out  output word
//    M_TREADY        in   downstream accepts the word
//    M_TLAST         out  last beat of a packet, 0 when TLAST is compiled out
//    ERR_PROTO       out  sticky protocol error, cleared only by RST
//
// Build option
//    FIFO_STREAM_READER_TLAST_EN  when defined, a beat counter drives M_TLAST
//                                 every PKT_LEN handshakes; when undefined,
//                                 no counter exists and M_TLAST is 0.
// ============================================================================

module fifo_stream_reader
   import fifo_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int PKT_LEN = 16
) (
   input  logic             CLK,
   input  logic             RST,
   output logic             FIFO_RD_EN,
   input  logic             FIFO_VALID,
   input  logic [WIDTH-1:0] FIFO_RD_DATA,
   input  logic             FIFO_EMPTY,
   input  logic             FIFO_UNDERFLOW,
   output logic             M_TVALID,
   output logic [WIDTH-1:0] M_TDATA,
   input  logic             M_TREADY,
   output logic             M_TLAST,
   output logic             ERR_PROTO
);

   logic     infl_q;
   logic     infl_d;
   logic     err_q;
   logic     err_d;

   buf_cnt_t bufCnt;
   logic     bufPush;
   logic     bufPop;
   logic     rdEn;
   logic     outValid;
   logic [2:0] committed;

   // Read issue. Every word already buffered or still on its way back from
   // the FIFO has a reserved slot, so a new read is only issued while that
   // total is below the buffer depth. M_TREADY deliberately plays no part:
   // that keeps the downstream ready off the FIFO read-enable path, and the
   // third buffer slot is what lets us get away without it.
   always_comb begin
      committed = {1'b0, bufCnt} + {2'b00, infl_q};
      rdEn      = ~RST & ~FIFO_EMPTY & (committed < 3'(STREAM_BUF_DEPTH));
   end

   // In-flight tracking and error detection. The FIFO answers a read exactly
   // one cycle later, so "a read is in flight" is just last cycle's RD_EN.
   // A word only enters the buffer when it was asked for; a word nobody asked
   // for is dropped. Any mismatch between requests and returns, or an
   // underflow reported by the FIFO, latches the sticky error.
   always_comb begin
      infl_d  = rdEn;
      bufPush = FIFO_VALID & infl_q;
      err_d   = err_q
              | (FIFO_VALID & ~infl_q)
              | (~FIFO_VALID & infl_q)
              | FIFO_UNDERFLOW;
   end

   // State register for the in-flight flag and the sticky error.
   always_ff @(posedge CLK) begin
      if (RST) begin
         infl_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         infl_q <= infl_d;
         err_q  <= err_d;
      end
   end

   // Output side of the stream. Valid is simply "the buffer holds something",
   // forced low during reset so nothing leaks out while the rest of the
   // system is being cleared. A handshake releases the head word.
   always_comb begin
      outValid = ~RST & (bufCnt != buf_cnt_t'(0));
      bufPop   = outValid & M_TREADY;
   end

   stream_buf #(
      .WIDTH  (WIDTH)
   ) u_buf (
      .CLK    (CLK),
      .RST    (RST),
      .push_i (bufPush),
      .pop_i  (bufPop),
      .data_i (FIFO_RD_DATA),
      .data_o (M_TDATA),
      .cnt_o  (bufCnt)
   );

   // Drive the remaining outputs. The error flag is gated with RST so it
   // reads clear for the whole reset pulse, not just after the first edge.
   always_comb begin
      FIFO_RD_EN = rdEn;
      M_TVALID   = outValid;
      ERR_PROTO  = ~RST & err_q;
   end

`ifdef FIFO_STREAM_READER_TLAST_EN

   // One extra bit beyond $clog2 keeps the counter at least one bit wide
   // for PKT_LEN = 1, where the final beat is every beat.
   localparam int BEAT_W = $clog2(PKT_LEN) + 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

   logic [BEAT_W-1:0] beat_q;
   logic [BEAT_W-1:0] beat_d;

   // Beat counter. It advances only on an accepted beat, so a stalled word
   // keeps its TLAST value, and it wraps after the last beat of a packet.
   always_comb begin
      beat_d = beat_q;
      if (bufPop) begin
         if (beat_q == LAST_BEAT) begin
            beat_d = '0;
         end else begin
            beat_d = beat_q + BEAT_W'(1);
         end
      end
   end

   // Beat counter register; reset starts the next packet from beat 0.
   always_ff @(posedge CLK) begin
      if (RST) begin
         beat_q <= '0;
      end else begin
         beat_q <= beat_d;
      end
   end

   // TLAST marks the word currently offered, and only while it is valid.
   always_comb begin
      M_TLAST = outValid & (beat_q == LAST_BEAT);
   end

`else

   // Without packet framing TLAST is constant zero. PKT_LEN still appears in
   // the expression so the parameter list means the same in both builds.
   always_comb begin
      M_TLAST = 1'b0 & (PKT_LEN < 1);
   end

`endif

endmodule
